// File: rtl/mrs_8.sv
// mrs_8: registered 8-bit masking rotating shifter.
// One shared log rotator handles all four modes; the shift modes clear the wrapped bits with a mask.
module mrs_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mrsdata,
    input  logic [2:0] mrssel,
    input  logic [1:0] mode,
    output logic [7:0] mrsout,
    output logic       mrsvalid
);

    logic [7:0] stage1;
    logic [7:0] stage2;
    logic [7:0] stage4;
    logic [7:0] mask;
    logic [7:0] result;

    // mode[0] picks the rotate direction at every stage: 0 = right, 1 = left.
    always_comb begin
        stage1 = mrsdata;
        if (mrssel[0]) begin
            stage1 = mode[0] ? {mrsdata[6:0], mrsdata[7]} : {mrsdata[0], mrsdata[7:1]};
        end

        stage2 = stage1;
        if (mrssel[1]) begin
            stage2 = mode[0] ? {stage1[5:0], stage1[7:6]} : {stage1[1:0], stage1[7:2]};
        end

        stage4 = stage2;
        if (mrssel[2]) begin
            stage4 = {stage2[3:0], stage2[7:4]};
        end
    end

    // The mask keeps only the bits a true logical shift would keep; rotates pass everything.
    always_comb begin
        mask = 8'hFF;
        if (mode[1]) begin
            mask = mode[0] ? (8'hFF << mrssel) : (8'hFF >> mrssel);
        end
        result = stage4 & mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mrsout   <= 8'h00;
            mrsvalid <= 1'b0;
        end else begin
            mrsout   <= result;
            mrsvalid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mrs_8.sv
// tb_mrs_8: self-checking bench for mrs_8.
// Expected results come from a bit-index rotate/shift model evaluated straight from the operation definitions.
module tb_mrs_8;

    logic       clk;
    logic       rst;
    logic [7:0] mrsdata;
    logic [2:0] mrssel;
    logic [1:0] mode;
    logic [7:0] mrsout;
    logic       mrsvalid;

    int vectors;
    int errors;

    mrs_8 dut (
        .clk      (clk),
        .rst      (rst),
        .mrsdata  (mrsdata),
        .mrssel   (mrssel),
        .mode     (mode),
        .mrsout   (mrsout),
        .mrsvalid (mrsvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] d, input int n, input logic [1:0] m);
        logic [7:0] r;
        r = 8'h00;
        case (m)
            2'b00: for (int i = 0; i < 8; i++) r[i] = d[(i + n) % 8];
            2'b01: for (int i = 0; i < 8; i++) r[i] = d[(i + 8 - n) % 8];
            2'b10: r = d >> n;
            default: r = d << n;
        endcase
        return r;
    endfunction

    // Inputs change on the falling edge so they are stable well before the next rising edge.
    task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        @(negedge clk);
        mrsdata = d;
        mrssel  = s;
        mode    = m;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        mrsdata = 8'hA5;
        mrssel  = 3'd1;
        mode    = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (mrsout !== 8'h00 || mrsvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got out=%h valid=%b, expected out=00 valid=0", mrsout, mrsvalid);
            end
        end
        @(negedge clk);
        rst     = 1'b0;
        mrsdata = 8'h00;
        mrssel  = 3'd0;
        mode    = 2'b00;
        #1;
        vectors++;
        if (mrsvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_pre_edge: got valid=%b, expected 0", mrsvalid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (mrsout !== 8'h00 || mrsvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_edge: got out=%h valid=%b, expected out=00 valid=1", mrsout, mrsvalid);
        end
    endtask

    task automatic test_directed();
        logic [7:0] exp [10];
        logic [2:0] sels [10];
        logic [1:0] modes [10];
        exp   = '{8'hD2, 8'h69, 8'h2D, 8'h5A, 8'h05, 8'h02, 8'h80, 8'hA5, 8'hA5, 8'hA5};
        sels  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0};
        modes = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        for (int k = 0; k < 10; k++) begin
            drive(8'hA5, sels[k], modes[k]);
            @(posedge clk);
            #1;
            vectors++;
            if (mrsout !== exp[k]) begin
                errors++;
                $display("[TB] FAIL directed_%0d mode=%b sel=%0d: got %h, expected %h", k, modes[k], sels[k], mrsout, exp[k]);
            end
        end
        drive(8'hA5, 3'd0, 2'b11);
        @(posedge clk);
        #1;
        vectors++;
        if (mrsout !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL directed_sll_sel0: got %h, expected a5", mrsout);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] pats [8];
        logic [7:0] e;
        pats = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'hA5, 8'h3C,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        for (int p = 0; p < 8; p++) begin
            for (int m = 0; m < 4; m++) begin
                for (int s = 0; s < 8; s++) begin
                    drive(pats[p], 3'(s), 2'(m));
                    e = model(pats[p], s, 2'(m));
                    @(posedge clk);
                    #1;
                    vectors++;
                    if (mrsout !== e || mrsvalid !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL sweep d=%h mode=%0d sel=%0d: got %h valid=%b, expected %h valid=1",
                                 pats[p], m, s, mrsout, mrsvalid, e);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [2:0] s;
        logic [1:0] m;
        logic [7:0] e;
        for (int k = 0; k < 200; k++) begin
            d = 8'($urandom);
            s = 3'($urandom);
            m = 2'($urandom);
            drive(d, s, m);
            e = model(d, int'(s), m);
            @(posedge clk);
            #1;
            vectors++;
            if (mrsout !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back d=%h mode=%0d sel=%0d: got %h, expected %h", d, m, s, mrsout, e);
            end
        end
    endtask

    task automatic test_input_hold();
        drive(8'h96, 3'd3, 2'b00);
        @(posedge clk);
        #1;
        mrsdata = 8'h11;
        mrssel  = 3'd7;
        mode    = 2'b11;
        #2;
        vectors++;
        if (mrsout !== model(8'h96, 3, 2'b00)) begin
            errors++;
            $display("[TB] FAIL input_hold: got %h, expected %h", mrsout, model(8'h96, 3, 2'b00));
        end
        @(posedge clk);
        #1;
        vectors++;
        if (mrsout !== 8'h80) begin
            errors++;
            $display("[TB] FAIL input_hold_next_edge: got %h, expected 80", mrsout);
        end
    endtask

    task automatic test_async_reset();
        drive(8'h5A, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        vectors++;
        if (mrsout !== model(8'h5A, 2, 2'b01)) begin
            errors++;
            $display("[TB] FAIL async_pre: got %h, expected %h", mrsout, model(8'h5A, 2, 2'b01));
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (mrsout !== 8'h00 || mrsvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_mid_cycle: got out=%h valid=%b, expected out=00 valid=0", mrsout, mrsvalid);
        end
        @(negedge clk);
        rst     = 1'b0;
        mrsdata = 8'hC3;
        mrssel  = 3'd7;
        mode    = 2'b10;
        #1;
        vectors++;
        if (mrsout !== 8'h00 || mrsvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_discard: got out=%h valid=%b, expected out=00 valid=0", mrsout, mrsvalid);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (mrsout !== 8'h01 || mrsvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset_recover: got out=%h valid=%b, expected out=01 valid=1", mrsout, mrsvalid);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        mrsdata = 8'h00;
        mrssel  = 3'd0;
        mode    = 2'b00;
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_input_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
